// File: rtl/common_pkg.sv
// Shared types for the CLIC scheduler: table entry layout, scheduler states
// and the eligibility rule used by the priority search.
package common_pkg;

    localparam int NR_INDEX_BITS = 4;
    localparam int NR_PRIO_BITS  = 3;

    typedef logic [NR_INDEX_BITS-1:0] Index;
    typedef logic [NR_PRIO_BITS-1:0]  Prio;

    typedef struct packed {
        logic pending;
        logic enable;
        Prio  prio;
    } TableEntry;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        CLAIMED = 2'd2
    } SchedState;

    // Priority 0 can never exceed any level, so it never interrupts.
    function automatic logic is_eligible(input TableEntry e, input Prio level);
        return e.pending && e.enable && (e.prio > level);
    endfunction

endpackage

// File: rtl/clic_select.sv
// Combinational masked maximum search: highest-priority eligible entry above
// the running level, lowest index on a tie.
module clic_select
    import common_pkg::*;
#(
    parameter int N = 2 ** NR_INDEX_BITS
) (
    input  TableEntry i_table [N],
    input  Prio       i_level,
    output logic      o_found,
    output Index      o_index,
    output Prio       o_prio
);

    logic w_found;
    Index w_index;
    Prio  w_prio;

    always_comb begin
        w_found = 1'b0;
        w_index = '0;
        w_prio  = '0;
        // Strict greater-than while scanning upward keeps the lowest index on a tie.
        for (int i = 0; i < N; i++) begin
            if (is_eligible(i_table[i], i_level) && (!w_found || (i_table[i].prio > w_prio))) begin
                w_found = 1'b1;
                w_index = Index'(i);
                w_prio  = i_table[i].prio;
            end
        end
    end

    assign o_found = w_found;
    assign o_index = w_index;
    assign o_prio  = w_prio;

endmodule

// File: rtl/clic_scheduler.sv
// CLIC interrupt scheduler: entry table, nested level stack and a registered
// valid/ready claim offer toward the core.
module clic_scheduler
    import common_pkg::*;
#(
    parameter  int NEST_DEPTH = 4,
    localparam int N          = 2 ** NR_INDEX_BITS,
    localparam int DEPTH_W    = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       irq_src,
    input  logic               cfg_we,
    input  Index               cfg_index,
    input  Prio                cfg_prio,
    input  logic               cfg_enable,
    input  logic               cfg_pending_clr,
    output logic               irq_valid,
    output Index               irq_index,
    output Prio                irq_prio,
    input  logic               irq_ready,
    input  logic               irq_complete,
    output Prio                level,
    output logic [DEPTH_W-1:0] depth,
    output SchedState          dbg_state
);

    // Handshake: an offer is taken in any cycle where irq_valid and irq_ready
    // are both high; irq_index/irq_prio are stable registers for that cycle,
    // and the offer may be withdrawn or upgraded while irq_ready is low.

    localparam int                 SP_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(NEST_DEPTH);

    TableEntry           r_table [N];
    Prio                 r_stack [NEST_DEPTH];
    Prio                 r_level;
    logic [DEPTH_W-1:0]  r_depth;
    SchedState           r_state;
    logic                r_valid;
    Index                r_index;
    Prio                 r_prio;

    logic                w_found;
    Index                w_index;
    Prio                 w_prio;
    logic                w_full;
    logic                w_claim;
    logic                w_pop;
    logic [SP_W-1:0]     w_push_sp;
    logic [SP_W-1:0]     w_pop_sp;

    clic_select #(.N(N)) u_select (
        .i_table (r_table),
        .i_level (r_level),
        .o_found (w_found),
        .o_index (w_index),
        .o_prio  (w_prio)
    );

    assign w_full    = (r_depth == FULL);
    assign w_claim   = r_valid & irq_ready;
    assign w_pop     = irq_complete & (r_depth != '0);
    assign w_push_sp = SP_W'(r_depth);
    assign w_pop_sp  = SP_W'(r_depth - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_table[i] <= '0;
            end
            for (int k = 0; k < NEST_DEPTH; k++) begin
                r_stack[k] <= '0;
            end
            r_level <= '0;
            r_depth <= '0;
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_index <= '0;
            r_prio  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if ((w_claim && (r_index == Index'(i))) ||
                    (cfg_we && cfg_pending_clr && (cfg_index == Index'(i)))) begin
                    r_table[i].pending <= 1'b0;
                end
                // Later assignment wins: a new event beats a same-cycle clear.
                if (irq_src[i]) begin
                    r_table[i].pending <= 1'b1;
                end
                if (cfg_we && (cfg_index == Index'(i))) begin
                    r_table[i].enable <= cfg_enable;
                    r_table[i].prio   <= cfg_prio;
                end
            end

            // Claim plus complete: the pushed level equals the popped one, so the stack is untouched.
            if (w_claim && w_pop) begin
                r_level <= r_prio;
            end else if (w_claim && !w_full) begin
                r_stack[w_push_sp] <= r_level;
                r_level            <= r_prio;
                r_depth            <= r_depth + 1'b1;
            end else if (w_pop) begin
                r_level <= r_stack[w_pop_sp];
                r_depth <= r_depth - 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_found && !w_full) begin
                        r_state <= OFFER;
                        r_valid <= 1'b1;
                        r_index <= w_index;
                        r_prio  <= w_prio;
                    end
                end
                OFFER: begin
                    if (w_claim) begin
                        r_state <= CLAIMED;
                        r_valid <= 1'b0;
                    end else if (!w_found || w_full) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end else begin
                        r_index <= w_index;
                        r_prio  <= w_prio;
                    end
                end
                CLAIMED: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign irq_valid = r_valid;
    assign irq_index = r_index;
    assign irq_prio  = r_prio;
    assign level     = r_level;
    assign depth     = r_depth;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_clic_scheduler.sv
// Directed bench for clic_scheduler: a per-cycle vector table covering the
// claim/complete/nesting scenarios plus hand-written latency sequences.
module tb_clic_scheduler;
    import common_pkg::*;

    localparam int N = 2 ** NR_INDEX_BITS;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         irq_src;
    logic                 cfg_we;
    Index                 cfg_index;
    Prio                  cfg_prio;
    logic                 cfg_enable;
    logic                 cfg_pending_clr;
    logic                 irq_valid;
    Index                 irq_index;
    Prio                  irq_prio;
    logic                 irq_ready;
    logic                 irq_complete;
    Prio                  level;
    logic [2:0]           depth;
    SchedState            dbg_state;

    typedef struct {
        logic [15:0] src;
        logic        we;
        int          idx;
        int          pr;
        logic        en;
        logic        clr;
        logic        rdy;
        logic        cmp;
        logic        rst;
        logic        chk;
        logic        ev;
        int          ei;
        int          ep;
        int          el;
        int          ed;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    clic_scheduler #(.NEST_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .irq_src         (irq_src),
        .cfg_we          (cfg_we),
        .cfg_index       (cfg_index),
        .cfg_prio        (cfg_prio),
        .cfg_enable      (cfg_enable),
        .cfg_pending_clr (cfg_pending_clr),
        .irq_valid       (irq_valid),
        .irq_index       (irq_index),
        .irq_prio        (irq_prio),
        .irq_ready       (irq_ready),
        .irq_complete    (irq_complete),
        .level           (level),
        .depth           (depth),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        irq_src         = '0;
        cfg_we          = 1'b0;
        cfg_index       = '0;
        cfg_prio        = '0;
        cfg_enable      = 1'b0;
        cfg_pending_clr = 1'b0;
        irq_ready       = 1'b0;
        irq_complete    = 1'b0;
    endtask

    // Inputs applied for one cycle, then state expected just after that edge.
    task automatic row(input logic [15:0] src, input logic we, input int idx, input int pr,
                       input logic en, input logic clr, input logic rdy, input logic cmp,
                       input logic rst, input logic chk, input logic ev, input int ei,
                       input int ep, input int el, input int ed);
        vec_t v;
        v.src = src; v.we = we; v.idx = idx; v.pr = pr; v.en = en; v.clr = clr;
        v.rdy = rdy; v.cmp = cmp; v.rst = rst; v.chk = chk; v.ev = ev;
        v.ei = ei; v.ep = ep; v.el = el; v.ed = ed;
        vecs.push_back(v);
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        idle_inputs();
        repeat (2) step();
        check("reset valid", int'(irq_valid), 0);
        check("reset index", int'(irq_index), 0);
        check("reset prio", int'(irq_prio), 0);
        check("reset level", int'(level), 0);
        check("reset depth", int'(depth), 0);
        check("reset state", int'(dbg_state), int'(IDLE));
        reset = 1'b0;

        //   src       we idx pr en clr rdy cmp rst chk ev ei ep  el ed
        // single claim of entry 5 at prio 3
        row(16'h0000, 1,  5, 3, 1, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0020, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 5, 3,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        // tie between entries 2 and 9 at prio 4
        row(16'h0000, 1,  2, 4, 1, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 1,  9, 4, 1, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0204, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 2, 4,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 2, 4,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  4, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  4, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  4, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 9, 4,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  4, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        // preemption by prio 6, prio 2 held off until thread mode
        row(16'h0000, 1,  6, 6, 1, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 1,  7, 2, 1, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0020, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 5, 3,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0040, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 6, 6,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  6, 2);
        row(16'h0080, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  6, 2);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  6, 2);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 7, 2,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  2, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        // fill the stack with prios 1..4, prio 7 waits for a complete
        row(16'h0000, 1,  1, 1, 1, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 1, 12, 7, 1, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0002, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 1, 1,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  1, 1);
        row(16'h0080, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  1, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 7, 2,  1, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  2, 2);
        row(16'h0020, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  2, 2);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 5, 3,  2, 2);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  3, 3);
        row(16'h0004, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  3, 3);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 2, 4,  3, 3);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  4, 4);
        row(16'h1000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  4, 4);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  4, 4);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  4, 4);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  3, 3);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1,12, 7,  3, 3);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  7, 4);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  3, 3);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  2, 2);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  1, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  0, 0);
        // event during claim keeps pending; claim+complete in one cycle
        row(16'h0020, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 5, 3,  0, 0);
        row(16'h0020, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 5, 3,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0040, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 6, 6,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  1,  0,  1, 0, 0, 0,  6, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  1,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        // configuration writes against a live offer
        row(16'h0020, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 5, 3,  0, 0);
        row(16'h0000, 1,  5, 3, 0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 1,  5, 3, 1, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 5, 3,  0, 0);
        row(16'h0000, 1,  5, 5, 1, 0,  1,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0020, 1,  5, 5, 1, 1,  0,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 5, 5,  3, 1);
        row(16'h0000, 1,  5, 5, 1, 1,  0,  0,  0,  0, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  3, 1);
        // reset while two handlers are active
        row(16'h0040, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1, 6, 6,  3, 1);
        row(16'h0000, 0,  0, 0, 0, 0,  1,  0,  0,  1, 0, 0, 0,  6, 2);
        row(16'h1000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  6, 2);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 1,12, 7,  6, 2);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  1,  1, 0, 0, 0,  0, 0);
        row(16'h0000, 0,  0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  0, 0);

        foreach (vecs[n]) begin
            irq_src         = vecs[n].src;
            cfg_we          = vecs[n].we;
            cfg_index       = Index'(vecs[n].idx);
            cfg_prio        = Prio'(vecs[n].pr);
            cfg_enable      = vecs[n].en;
            cfg_pending_clr = vecs[n].clr;
            irq_ready       = vecs[n].rdy;
            irq_complete    = vecs[n].cmp;
            reset           = vecs[n].rst;
            step();
            if (vecs[n].chk) begin
                check($sformatf("row%0d valid", n), int'(irq_valid), int'(vecs[n].ev));
                if (vecs[n].ev) begin
                    check($sformatf("row%0d index", n), int'(irq_index), vecs[n].ei);
                    check($sformatf("row%0d prio", n), int'(irq_prio), vecs[n].ep);
                end
            end
            check($sformatf("row%0d level", n), int'(level), vecs[n].el);
            check($sformatf("row%0d depth", n), int'(depth), vecs[n].ed);
        end
        idle_inputs();
        reset = 1'b0;

        // Source-to-offer latency, then claim -> complete -> re-offer latency.
        cfg_we = 1'b1; cfg_index = 4'd3; cfg_prio = 3'd2; cfg_enable = 1'b1;
        step();
        cfg_index = 4'd4; cfg_prio = 3'd5;
        step();
        idle_inputs();
        irq_src = 16'h0018;
        step();
        irq_src = '0;
        lat = 1;
        while (!irq_valid && lat < 10) begin
            step();
            lat++;
        end
        check("src_to_valid latency", lat, 2);
        check("seq offer index", int'(irq_index), 4);
        check("seq offer prio", int'(irq_prio), 5);

        irq_ready = 1'b1;
        step();
        irq_ready = 1'b0;
        check("seq claim level", int'(level), 5);
        check("seq claim depth", int'(depth), 1);
        irq_complete = 1'b1;
        step();
        irq_complete = 1'b0;
        check("seq complete level", int'(level), 0);
        check("seq complete depth", int'(depth), 0);
        lat = 2;
        while (!irq_valid && lat < 10) begin
            step();
            lat++;
        end
        check("claim_to_reoffer latency", lat, 3);
        check("seq reoffer index", int'(irq_index), 3);
        check("seq reoffer prio", int'(irq_prio), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
